parallel_to_serial_tx: RTL

Byte-wide parallel-to-serial transmitter: accepts an 8-bit character on a load handshake and shifts it onto a single serial line as one frame of start bit, 8 data bits MSB-first, and stop bit. It is the transmit end of the serial link whose receive end shifts bits into a byte register and presents the character on `charReceive`. A one-deep holding register allows back-to-back frames with no idle gap.

---
 rtl/parallel_to_serial_tx_if.sv | 28 ++
 rtl/parallel_to_serial_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/parallel_to_serial_tx_if.sv
// Load handshake and serial line bundle for the
// byte-wide serial transmitter.
interface parallel_to_serial_tx_if;
  logic [7:0] dataIn;
  logic       load;
  logic       ready;
  logic       busy;
  logic       serout;
  logic       charSent;

  modport master (
    output dataIn,
    output load,
    input  ready,
    input  busy,
    input  serout,
    input  charSent
  );

  modport slave (
    input  dataIn,
    input  load,
    output ready,
    output busy,
    output serout,
    output charSent
  );
endinterface

// File: rtl/parallel_to_serial_tx.sv
// Byte-wide serial transmitter: start, 8 data MSB-first, stop.
// A one-deep hold register lets frames run back to back.
module parallel_to_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic clk,
  input logic reset,
  parallel_to_serial_tx_if.slave tx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0] LAST =
    8'(CLKS_PER_BIT - 1);

  logic [1:0] state;
  logic [1:0] state_n;
  logic [7:0] tick;
  logic [7:0] tick_n;
  logic [2:0] bit_idx;
  logic [2:0] bit_n;
  logic [7:0] shift;
  logic [7:0] shift_n;
  logic [7:0] hold;
  logic [7:0] hold_n;
  logic       hold_vld;
  logic       hold_vld_n;
  logic       serout_q;
  logic       serout_n;
  logic       ready_q;
  logic       sent_q;
  logic       sent_n;
  logic       accept;
  logic       last;
  logic       leaving;

  assign accept = tx.load && ready_q;
  assign last   = (tick == LAST);

  // Last tick of the stop bit hands over directly to the next frame.
  assign leaving = (state == STOP) && last;

  always_comb begin
    state_n    = state;
    tick_n     = last ? 8'd0 : tick + 8'd1;
    bit_n      = bit_idx;
    shift_n    = shift;
    hold_n     = hold;
    hold_vld_n = hold_vld;
    sent_n     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        tick_n = 8'd0;
        if (accept) begin
          shift_n = tx.dataIn;
          state_n = START;
        end
      end
      (state == START): begin
        if (last) begin
          state_n = DATA;
          bit_n   = 3'd0;
        end
      end
      (state == DATA): begin
        if (last) begin
          shift_n = {shift[6:0], 1'b0};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_n = STOP;
        end
      end
      (state == STOP): begin
        if (last) begin
          sent_n = 1'b1;
          if (hold_vld) begin
            shift_n    = hold;
            hold_vld_n = 1'b0;
            state_n    = START;
          end else if (accept) begin
            shift_n = tx.dataIn;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept && state != IDLE && !leaving) begin
      hold_n     = tx.dataIn;
      hold_vld_n = 1'b1;
    end

    unique case (1'b1)
      (state_n == START): serout_n = 1'b0;
      (state_n == DATA):  serout_n = shift_n[7];
      default:            serout_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= 8'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      hold     <= 8'd0;
      hold_vld <= 1'b0;
      serout_q <= 1'b1;
      ready_q  <= 1'b1;
      sent_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      hold     <= hold_n;
      hold_vld <= hold_vld_n;
      serout_q <= serout_n;
      ready_q  <= !hold_vld_n;
      sent_q   <= sent_n;
    end
  end

  assign tx.serout   = serout_q;
  assign tx.ready    = ready_q;
  assign tx.busy     = (state != IDLE);
  assign tx.charSent = sent_q;

endmodule
